// File: rtl/axi_write_burst_ctrl.sv
// AXI4 write-burst master: takes one NBEATS-beat burst from a valid/ready front end and completes it on AW/W/B.
// Optional retry-on-error behaviour is compiled in with `define IOB_CACHE_AXI_RETRY_EN.
module axi_write_burst_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 2,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_ID    = 0,
    parameter int MAX_RETRY = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   valid,
    input  logic [ADDR_W-1:0]                      addr,
    input  logic [DATA_W*(2**BURST_W)-1:0]         wdata,
    input  logic [(DATA_W/8)*(2**BURST_W)-1:0]     wstrb,
    output logic                                   ready,
    output logic                                   ack,
    output logic                                   err,
    output logic                                   axi_awvalid,
    input  logic                                   axi_awready,
    output logic [ADDR_W-1:0]                      axi_awaddr,
    output logic [7:0]                             axi_awlen,
    output logic [2:0]                             axi_awsize,
    output logic [1:0]                             axi_awburst,
    output logic [0:0]                             axi_awlock,
    output logic [3:0]                             axi_awcache,
    output logic [2:0]                             axi_awprot,
    output logic [3:0]                             axi_awqos,
    output logic [AXI_ID_W-1:0]                    axi_awid,
    output logic                                   axi_wvalid,
    input  logic                                   axi_wready,
    output logic [DATA_W-1:0]                      axi_wdata,
    output logic [DATA_W/8-1:0]                    axi_wstrb,
    output logic                                   axi_wlast,
    input  logic                                   axi_bvalid,
    input  logic [1:0]                             axi_bresp,
    output logic                                   axi_bready
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BYTE_W = $clog2(NBYTES);
    localparam int NBEATS = 2 ** BURST_W;
    localparam int BEAT_W = (BURST_W > 0) ? BURST_W : 1;
    localparam int LOW_W  = BYTE_W + BURST_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << LOW_W) - ADDR_W'(1));
    localparam logic [1:0]        RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [DATA_W*NBEATS-1:0]      wdata_q, wdata_d;
    logic [NBYTES*NBEATS-1:0]      wstrb_q, wstrb_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic                          ack_q, ack_d;
    logic                          err_q, err_d;
    logic                          ready_q, ready_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          bready_q, bready_d;

`ifdef IOB_CACHE_AXI_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0]            retry_q, retry_d;
`endif

    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign aw_hs = awvalid_q & axi_awready;
    assign w_hs  = wvalid_q & axi_wready;
    assign b_hs  = bready_q & axi_bvalid;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        beat_d    = beat_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
`ifdef IOB_CACHE_AXI_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid && ready_q) begin
                    addr_d    = addr & ADDR_MASK;
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    beat_d    = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    if (beat_q == LAST_BEAT) begin
                        w_done_d = 1'b1;
                        beat_d   = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                // Both channels may finish on the same edge; RESP starts the following cycle.
                if (aw_done_d && w_done_d) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    if (axi_bresp == RESP_OKAY) begin
                        ack_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
`ifdef IOB_CACHE_AXI_RETRY_EN
                        if (retry_q < RETRY_MAX) begin
                            retry_d   = retry_q + 1'b1;
                            aw_done_d = 1'b0;
                            w_done_d  = 1'b0;
                            beat_d    = '0;
                            state_d   = SEND;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
`else
                        err_d   = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef IOB_CACHE_AXI_RETRY_EN
        if (state_d == IDLE) begin
            retry_d = '0;
        end
`endif
        // ready stays low during the ack/err pulse so the two are never seen together.
        ready_d   = (state_d == IDLE) && !ack_d && !err_d;
        awvalid_d = (state_d == SEND) && !aw_done_d;
        wvalid_d  = (state_d == SEND) && !w_done_d;
        bready_d  = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
`ifdef IOB_CACHE_AXI_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
`ifdef IOB_CACHE_AXI_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    // Payload registers carry no reset; they are only read after a request has been latched.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    assign ready       = ready_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = 8'(NBEATS - 1);
    assign axi_awsize  = 3'(BYTE_W);
    assign axi_awburst = (BURST_W > 0) ? 2'b01 : 2'b00;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = 4'b0011;
    assign axi_awprot  = 3'b000;
    assign axi_awqos   = 4'b0000;
    assign axi_awid    = AXI_ID_W'(AXI_ID);
    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wdata_q[beat_q*DATA_W +: DATA_W];
    assign axi_wstrb   = wstrb_q[beat_q*NBYTES +: NBYTES];
    assign axi_wlast   = (beat_q == LAST_BEAT);
    assign axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_write_burst_ctrl.sv
// Directed bench for axi_write_burst_ctrl: table of burst scenarios plus a mid-burst reset sequence.
`timescale 1ns/1ps
module tb_axi_write_burst_ctrl;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 2;
    localparam int NBYTES  = 4;
    localparam int NBEATS  = 4;
`ifdef IOB_CACHE_AXI_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        valid = 1'b0;
    logic [ADDR_W-1:0]           addr = '0;
    logic [DATA_W*NBEATS-1:0]    wdata = '0;
    logic [NBYTES*NBEATS-1:0]    wstrb = '0;
    logic                        ready, ack, err;
    logic                        axi_awvalid;
    logic                        axi_awready = 1'b0;
    logic [ADDR_W-1:0]           axi_awaddr;
    logic [7:0]                  axi_awlen;
    logic [2:0]                  axi_awsize;
    logic [1:0]                  axi_awburst;
    logic [0:0]                  axi_awlock;
    logic [3:0]                  axi_awcache;
    logic [2:0]                  axi_awprot;
    logic [3:0]                  axi_awqos;
    logic [0:0]                  axi_awid;
    logic                        axi_wvalid;
    logic                        axi_wready = 1'b0;
    logic [DATA_W-1:0]           axi_wdata;
    logic [NBYTES-1:0]           axi_wstrb;
    logic                        axi_wlast;
    logic                        axi_bvalid = 1'b0;
    logic [1:0]                  axi_bresp = 2'b00;
    logic                        axi_bready;

    int checks = 0;
    int failures = 0;

    axi_write_burst_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
        .AXI_ID_W(1), .AXI_ID(0), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .ack(ack), .err(err),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awqos(axi_awqos), .axi_awid(axi_awid),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] wstrb;
        int          aw_delay;
        bit          wtoggle;
        logic [1:0]  bresp_first;
        logic [1:0]  bresp_rest;
        logic [31:0] exp_awaddr;
        int          exp_bursts;
        int          exp_ack;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_wdata(input int i);
        logic [127:0] r;
        for (int k = 0; k < NBEATS; k++)
            r[k*32 +: 32] = (32'h1111_1111 * 32'(k + 1)) ^ (32'(i) << 24) ^ 32'h0000_5A00;
        return r;
    endfunction

    // Called at a falling edge; returns at a falling edge with the block idle again.
    task automatic run_txn(input vec_t v, input logic [127:0] wd, input string tag);
        int  beat, bursts, wbeats, acks, errs, resp_idx, aw_cyc, lw_cyc, done_cyc, awv_cycles, waitc;
        bit  finished, awr, wr;
        waitc = 0;
        while (ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_ready_idle"}, 64'(ready), 64'd1);
        valid = 1'b1;
        addr  = v.addr;
        wdata = wd;
        wstrb = v.wstrb;
        @(negedge clk);
        valid = 1'b0;
        addr  = $urandom;
        wdata = {$urandom, $urandom, $urandom, $urandom};
        wstrb = 16'($urandom);
        check({tag, "_ready_busy"}, 64'(ready), 64'd0);
        beat = 0; bursts = 0; wbeats = 0; acks = 0; errs = 0; resp_idx = 0;
        aw_cyc = -1; lw_cyc = -1; done_cyc = -1; awv_cycles = 0; finished = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            awr = (c >= v.aw_delay);
            wr  = v.wtoggle ? (c % 2 == 0) : 1'b1;
            if (done_cyc >= 0) begin
                check({tag, "_ready_after_done"}, 64'(ready), 64'd1);
                check({tag, "_pulse_len"}, 64'({ack, err}), 64'd0);
                finished = 1'b1;
            end else begin
                if (ack || err) begin
                    check({tag, "_ready_during_pulse"}, 64'(ready), 64'd0);
                    check({tag, "_ack_err_excl"}, 64'(ack & err), 64'd0);
                    acks += int'(ack);
                    errs += int'(err);
                    done_cyc = c;
                end
                if (axi_wvalid && wr) begin
                    check({tag, "_wdata"}, 64'(axi_wdata), 64'(wd[beat*32 +: 32]));
                    check({tag, "_wstrb"}, 64'(axi_wstrb), 64'(v.wstrb[beat*4 +: 4]));
                    check({tag, "_wlast"}, 64'(axi_wlast), 64'(beat == NBEATS - 1));
                    beat++;
                    wbeats++;
                    if (beat == NBEATS) begin
                        beat = 0;
                        lw_cyc = c;
                    end
                end
                if (axi_awvalid) awv_cycles++;
                if (axi_awvalid && awr) begin
                    check({tag, "_awaddr"}, 64'(axi_awaddr), 64'(v.exp_awaddr));
                    check({tag, "_aw_const"},
                          64'({axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache,
                               axi_awprot, axi_awqos, axi_awid}),
                          64'({8'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0}));
                    aw_cyc = c;
                    bursts++;
                end
                if (axi_bready) begin
                    check({tag, "_resp_entry_cycle"}, 64'(c), 64'(((aw_cyc > lw_cyc) ? aw_cyc : lw_cyc) + 1));
                    axi_bvalid = 1'b1;
                    axi_bresp  = (resp_idx == 0) ? v.bresp_first : v.bresp_rest;
                    resp_idx++;
                end else begin
                    axi_bvalid = 1'b0;
                end
            end
            axi_awready = awr;
            axi_wready  = wr;
            @(negedge clk);
        end
        axi_bvalid = 1'b0;
        check({tag, "_completed"}, 64'(finished), 64'd1);
        check({tag, "_bursts"}, 64'(bursts), 64'(v.exp_bursts));
        check({tag, "_wbeats"}, 64'(wbeats), 64'(NBEATS * v.exp_bursts));
        check({tag, "_acks"}, 64'(acks), 64'(v.exp_ack));
        check({tag, "_errs"}, 64'(errs), 64'(v.exp_err));
        check({tag, "_awvalid_hold"}, 64'(awv_cycles), 64'(v.aw_delay + v.exp_bursts));
        if (v.aw_delay >= NBEATS && !v.wtoggle)
            check({tag, "_w_before_aw"}, 64'(lw_cyc < aw_cyc), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_1234, 16'hFFFF, 0, 1'b0, 2'b00, 2'b00, 32'h0000_1230, 1, 1, 0};
        vecs[1] = '{32'hABCD_EF7F, 16'hF00F, 5, 1'b0, 2'b00, 2'b00, 32'hABCD_EF70, 1, 1, 0};
        vecs[2] = '{32'h0000_0FFF, 16'h1248, 0, 1'b1, 2'b00, 2'b00, 32'h0000_0FF0, 1, 1, 0};
        vecs[3] = '{32'h8000_0008, 16'hA5C3, 2, 1'b1, 2'b10, 2'b10, 32'h8000_0000,
                    RETRY ? 4 : 1, 0, 1};
        vecs[4] = '{32'h0000_0040, 16'h0F0F, 0, 1'b0, 2'b10, 2'b00, 32'h0000_0040,
                    RETRY ? 2 : 1, RETRY ? 1 : 0, RETRY ? 0 : 1};
        vecs[5] = '{32'hFFFF_FFFF, 16'h8421, 1, 1'b1, 2'b11, 2'b01, 32'hFFFF_FFF0,
                    RETRY ? 4 : 1, 0, 1};

        #2 reset = 1'b0;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_valids", 64'({axi_awvalid, axi_wvalid, axi_bready}), 64'd0);
        check("rst_pulses", 64'({ack, err}), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_state", 64'({ready, axi_awvalid, axi_wvalid, axi_bready, ack, err}), 64'b100000);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i], mk_wdata(i), $sformatf("v%0d", i));

        // Reset while beat 2 is on the W channel and AW is still pending.
        begin
            logic [127:0] wd;
            int errack;
            wd = mk_wdata(9);
            axi_awready = 1'b0;
            axi_wready  = 1'b1;
            valid = 1'b1;
            addr  = 32'h0000_2000;
            wdata = wd;
            wstrb = 16'hFFFF;
            @(negedge clk);
            valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("mid_rst_beat2_data", 64'(axi_wdata), 64'(wd[64 +: 32]));
            check("mid_rst_beat2_valid", 64'(axi_wvalid), 64'd1);
            #2 reset = 1'b0;
            #1;
            check("mid_rst_valids_drop", 64'({axi_awvalid, axi_wvalid, axi_bready}), 64'd0);
            check("mid_rst_ready", 64'(ready), 64'd1);
            errack = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (ack || err) errack++;
            end
            reset = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (ack || err) errack++;
            end
            check("mid_rst_no_pulse", 64'(errack), 64'd0);
        end
        run_txn(vecs[0], mk_wdata(7), "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_write_burst_ctrl.md
AXI_WRITE_BURST_CTRL -- requirements
Module: axi_write_burst_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, AXI data width; NBYTES = DATA_W/8, BYTE_W = log2(NBYTES).
REQ-003 The block SHALL have parameter BURST_W, default 2, log2 of beats per request; legal range 0..8, so NBEATS = 2**BURST_W.
REQ-004 The block SHALL have parameter AXI_ID_W, default 1, ID width.
REQ-005 The block SHALL have parameter AXI_ID, default 0, constant transaction ID.
REQ-006 The block SHALL have parameter MAX_RETRY, default 3, retry limit, used only with the retry feature compiled in.
REQ-007 The block SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port valid, input, 1 bit: front-end request.
REQ-010 The block SHALL have port addr, input, ADDR_W bits: burst base byte address; bits [BYTE_W+BURST_W-1:0] are ignored and driven as zero on AXI.
REQ-011 The block SHALL have port wdata, input, DATA_W*NBEATS bits: beat k = wdata[k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port wstrb, input, NBYTES*NBEATS bits: beat k = wstrb[k*NBYTES +: NBYTES].
REQ-013 The block SHALL have port ready, output, 1 bit: high only in IDLE; valid&ready accepts a request.
REQ-014 The block SHALL have port ack, output, 1 bit: one-cycle pulse on successful completion.
REQ-015 The block SHALL have port err, output, 1 bit: one-cycle pulse on failed completion.
REQ-016 The block SHALL have the AXI AW ports axi_awvalid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awlock[0:0]/awcache[3:0]/awprot[2:0]/awqos[3:0]/awid (outputs) and axi_awready (input).
REQ-017 The block SHALL have the AXI W ports axi_wvalid/wdata[DATA_W]/wstrb[NBYTES]/wlast (outputs) and axi_wready (input).
REQ-018 The block SHALL have the AXI B ports axi_bvalid and axi_bresp[1:0] (inputs) and axi_bready (output).

Function
REQ-019 The block SHALL latch addr, wdata and wstrb into internal registers on valid&ready; front-end inputs SHALL be don't-care afterwards.
REQ-020 The block SHALL implement the states IDLE -> SEND -> RESP, returning to IDLE, or to SEND on retry.
REQ-021 In SEND, the block SHALL assert axi_awvalid until the AW handshake and axi_wvalid until the last-beat W handshake, independently; W beats MAY precede or coincide with AW acceptance.
REQ-022 A beat counter SHALL advance on axi_wvalid&axi_wready; axi_wlast SHALL be 1 only on beat NBEATS-1.
REQ-023 The block SHALL move from SEND to RESP in the cycle after both the AW and last-W handshakes have completed, including when both occur in the same cycle.
REQ-024 axi_bready SHALL be 1 only in RESP; B handshakes outside RESP are not possible.
REQ-025 On bresp==OKAY in RESP, the block SHALL pulse ack and return to IDLE.
REQ-026 The constant AXI outputs SHALL be: awlen=NBEATS-1; awsize=BYTE_W; awburst=01 (INCR) if BURST_W>0, else 00; awlock=0; awcache=0011; awprot=0; awqos=0; awid=AXI_ID.
REQ-027 ack and err SHALL never be high together, and neither SHALL be high while ready is high.

Reset
REQ-028 When reset is low, the block SHALL immediately enter IDLE and clear the beat counter, the AW/W done flags, the retry counter, ack and err.
REQ-029 While in reset, axi_awvalid, axi_wvalid and axi_bready SHALL be 0 and ready SHALL be 1.
REQ-030 An assertion of reset mid-burst SHALL abandon the transaction with no ack and no err.

Configuration
REQ-031 With macro IOB_CACHE_AXI_RETRY_EN defined, a non-OKAY bresp in RESP with retry count < MAX_RETRY SHALL increment the count and return to SEND, re-issuing AW and all beats from beat 0 with identical data.
REQ-032 With IOB_CACHE_AXI_RETRY_EN defined, a non-OKAY bresp with retry count == MAX_RETRY SHALL pulse err and return to IDLE; the retry count SHALL clear on every return to IDLE.
REQ-033 Without IOB_CACHE_AXI_RETRY_EN, any non-OKAY bresp SHALL pulse err and return to IDLE, and no retry counter SHALL exist.

Verification
REQ-034 BURST_W=2, awready and wready always 1, addr=0x1234: the bench SHALL see awaddr=0x1230, awlen=3, 4 beats with wlast only on beat 3, bresp=00 -> ack one cycle, ready high the next cycle.
REQ-035 awready held 0 for 5 cycles with wready=1: the bench SHALL see all 4 W beats complete first, awvalid held high, RESP entered the cycle after the AW handshake.
REQ-036 wready toggling 1/0 each cycle: beat data SHALL match wdata[k*32 +: 32] and wstrb[k*4 +: 4] per beat, and the beat counter SHALL hold while wready=0.
REQ-037 With IOB_CACHE_AXI_RETRY_EN and MAX_RETRY=3, bresp=10 every time: the bench SHALL see 4 full bursts, then err pulsed once, no ack.
REQ-038 With IOB_CACHE_AXI_RETRY_EN and MAX_RETRY=3, bresp=10 then 00: 2 bursts, then ack; without the macro, bresp=10 once -> err and no second burst.
REQ-039 Reset driven low during beat 2: the bench SHALL see all AXI valids drop asynchronously, no ack or err, and a new request after release SHALL start from beat 0.
